// File: rtl/rr_select_arbiter.sv
// Round-robin arbiter over four level-sensitive requesters.
// It drives the select/enable pair of a 2-to-4 decoder and limits each grant to MAX_HOLD cycles.
module rr_select_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    // "release" is a reserved word in SystemVerilog, so the port carries an _i suffix.
    input  logic       release_i,
    output logic [1:0] S,
    output logic       enable,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_e     state_q,   state_d;
    logic [1:0] last_q,    last_d;
    logic [7:0] hold_q,    hold_d;
    logic [1:0] s_q,       s_d;
    logic       enable_q,  enable_d;
    logic       timeout_q, timeout_d;

    logic       pick_valid_s;
    logic [1:0] pick_idx_s;
    logic [1:0] cand_s;
    logic       hold_hit_s;
    logic       req_drop_s;

    // Round-robin search: first set request starting just after the last grantee.
    always_comb begin
        pick_valid_s = 1'b0;
        pick_idx_s   = last_q;
        cand_s       = last_q;
        for (int k = 1; k <= 4; k++) begin
            cand_s = last_q + 2'(k);
            if (!pick_valid_s && req[cand_s]) begin
                pick_valid_s = 1'b1;
                pick_idx_s   = cand_s;
            end else begin
                pick_valid_s = pick_valid_s;
            end
        end
    end

    assign hold_hit_s = (hold_q == HOLD_LAST);
    assign req_drop_s = ~req[s_q];

    // Next-state and next-output logic for the IDLE/GRANT/GAP controller.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        hold_d    = hold_q;
        s_d       = s_q;
        enable_d  = enable_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (pick_valid_s) begin
                    state_d  = ST_GRANT;
                    s_d      = pick_idx_s;
                    enable_d = 1'b1;
                    hold_d   = 8'd0;
                end else begin
                    state_d  = ST_IDLE;
                    enable_d = 1'b0;
                end
            end
            ST_GRANT: begin
                if (release_i || req_drop_s || hold_hit_s) begin
                    state_d   = ST_GAP;
                    enable_d  = 1'b0;
                    last_d    = s_q;
                    // Only a pure hold-limit revocation is reported as a timeout.
                    timeout_d = hold_hit_s && !release_i && !req_drop_s;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                enable_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset leaves last at 3 so arbitration starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            last_q    <= 2'b11;
            hold_q    <= 8'd0;
            s_q       <= 2'b00;
            enable_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            s_q       <= s_d;
            enable_q  <= enable_d;
            timeout_q <= timeout_d;
        end
    end

    assign S       = s_q;
    assign enable  = enable_q;
    assign timeout = timeout_q;

endmodule
